seven_seg_scan: RTL

SEVEN_SEG_SCAN -- requirements
Module: seven_seg_scan

---
 rtl/seven_seg_scan_pkg.sv | 33 +++
 rtl/seven_seg_dec.sv | 37 +++
 rtl/seven_seg_scan.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/seven_seg_scan_pkg.sv
// rtl/seven_seg_scan_pkg.sv - shared segment codes and sizing helper for the seven-segment scanner
// Contents:
//   seg_t        7-bit segment vector {g,f,e,d,c,b,a}, active high
//   SEG_0..SEG_F glyphs for codes 0-15, SEG_BLANK all segments off
//   width_min1   $clog2 that never returns less than 1
package seven_seg_scan_pkg;

  typedef logic [6:0] seg_t;

  localparam seg_t SEG_BLANK = 7'b0000000;
  localparam seg_t SEG_0     = 7'b0111111;
  localparam seg_t SEG_1     = 7'b0000110;
  localparam seg_t SEG_2     = 7'b1011011;
  localparam seg_t SEG_3     = 7'b1001111;
  localparam seg_t SEG_4     = 7'b1100110;
  localparam seg_t SEG_5     = 7'b1101101;
  localparam seg_t SEG_6     = 7'b1111101;
  localparam seg_t SEG_7     = 7'b0000111;
  localparam seg_t SEG_8     = 7'b1111111;
  localparam seg_t SEG_9     = 7'b1101111;
  localparam seg_t SEG_A     = 7'b1110111;
  localparam seg_t SEG_B     = 7'b1111100;
  localparam seg_t SEG_C     = 7'b0111001;
  localparam seg_t SEG_D     = 7'b1011110;
  localparam seg_t SEG_E     = 7'b1111001;
  localparam seg_t SEG_F     = 7'b1110001;

  // Counters sized for a range of 1 still need one bit to be legal vectors.
  function automatic int width_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/seven_seg_dec.sv
// rtl/seven_seg_dec.sv - combinational 4-bit code to seven-segment decoder
// Ports:
//   code_i    4-bit digit code
//   hex_en_i  1 = codes 10-15 show A-F, 0 = codes 10-15 are blank
//   seg_o     segments {g,f,e,d,c,b,a}, active high
module seven_seg_dec
  import seven_seg_scan_pkg::*;
(
  input  logic [3:0] code_i,
  input  logic       hex_en_i,
  output seg_t       seg_o
);

  always_comb begin
    seg_o = SEG_BLANK;
    case (code_i)
      4'h0: seg_o = SEG_0;
      4'h1: seg_o = SEG_1;
      4'h2: seg_o = SEG_2;
      4'h3: seg_o = SEG_3;
      4'h4: seg_o = SEG_4;
      4'h5: seg_o = SEG_5;
      4'h6: seg_o = SEG_6;
      4'h7: seg_o = SEG_7;
      4'h8: seg_o = SEG_8;
      4'h9: seg_o = SEG_9;
      4'hA: seg_o = hex_en_i ? SEG_A : SEG_BLANK;
      4'hB: seg_o = hex_en_i ? SEG_B : SEG_BLANK;
      4'hC: seg_o = hex_en_i ? SEG_C : SEG_BLANK;
      4'hD: seg_o = hex_en_i ? SEG_D : SEG_BLANK;
      4'hE: seg_o = hex_en_i ? SEG_E : SEG_BLANK;
      4'hF: seg_o = hex_en_i ? SEG_F : SEG_BLANK;
      default: seg_o = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/seven_seg_scan.sv
// rtl/seven_seg_scan.sv - multiplexed seven-segment display scanner with frame-synchronous update
// Ports:
//   clk       clock, rising edge
//   rst       synchronous active-high reset
//   in        4*DIGITS digit codes, digit 0 in bits [3:0]
//   dp_in     DIGITS decimal-point requests
//   load      one-cycle strobe capturing in/dp_in into the pending register
//   en        display enable; 0 blanks outputs and freezes the scan
//   lz_blank  suppress leading zero digits (never digit 0)
//   seg       registered segments {g,f,e,d,c,b,a}
//   dp        registered decimal point of the driven digit
//   an        registered one-hot digit select
//   frame     one-cycle pulse when the scan index wraps to digit 0
module seven_seg_scan
  import seven_seg_scan_pkg::*;
#(
  parameter int DIGITS   = 4,
  parameter int PRESCALE = 1000,
  parameter int HEX      = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [4*DIGITS-1:0]   in,
  input  logic [DIGITS-1:0]     dp_in,
  input  logic                  load,
  input  logic                  en,
  input  logic                  lz_blank,
  output logic [6:0]            seg,
  output logic                  dp,
  output logic [DIGITS-1:0]     an,
  output logic                  frame
);

  localparam int   CNT_W  = width_min1(PRESCALE);
  localparam int   IDX_W  = width_min1(DIGITS);
  localparam logic HEX_EN = (HEX != 0);

  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [4*DIGITS-1:0] pend_code_q, pend_code_d;
  logic [DIGITS-1:0]   pend_dp_q, pend_dp_d;
  logic [4*DIGITS-1:0] disp_code_q, disp_code_d;
  logic [DIGITS-1:0]   disp_dp_q, disp_dp_d;
  seg_t                seg_q, seg_d;
  logic                dp_q, dp_d;
  logic [DIGITS-1:0]   an_q, an_d;
  logic                frame_q, frame_d;

  logic                digit_done;
  logic                wrap;
  logic [3:0]          cur_code;
  logic                cur_dp;
  logic                cur_lead;
  logic                lead_run;
  seg_t                dec_seg;

  // Scan timing: the counter and index only move while enabled.
  always_comb begin
    digit_done = en && (cnt_q == CNT_W'(PRESCALE - 1));
    wrap       = digit_done && (idx_q == IDX_W'(DIGITS - 1));
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    if (en) begin
      if (digit_done) begin
        cnt_d = '0;
        idx_d = wrap ? '0 : idx_q + IDX_W'(1);
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  // Double buffering: pending takes every load, displayed changes only at the
  // wrap. Feeding displayed from pend_*_d lets a load on the wrap cycle land in
  // the frame that starts right then.
  always_comb begin
    pend_code_d = load ? in    : pend_code_q;
    pend_dp_d   = load ? dp_in : pend_dp_q;
    disp_code_d = wrap ? pend_code_d : disp_code_q;
    disp_dp_d   = wrap ? pend_dp_d   : disp_dp_q;
  end

  // Digit mux plus leading-zero detection. lead_run stays high while every
  // digit from the top down to k is zero; digit 0 is never treated as leading.
  always_comb begin
    cur_code = 4'd0;
    cur_dp   = 1'b0;
    cur_lead = 1'b0;
    lead_run = 1'b1;
    for (int k = DIGITS - 1; k >= 0; k--) begin
      lead_run = lead_run && (disp_code_q[4*k +: 4] == 4'd0);
      if (idx_q == IDX_W'(k)) begin
        cur_code = disp_code_q[4*k +: 4];
        cur_dp   = disp_dp_q[k];
        cur_lead = lead_run && (k != 0);
      end
    end
  end

  seven_seg_dec u_dec (
    .code_i   (cur_code),
    .hex_en_i (HEX_EN),
    .seg_o    (dec_seg)
  );

  // Outputs are registered from the current index, giving one cycle of lag.
  always_comb begin
    seg_d = SEG_BLANK;
    dp_d  = 1'b0;
    an_d  = '0;
    if (en) begin
      seg_d = (lz_blank && cur_lead) ? SEG_BLANK : dec_seg;
      dp_d  = cur_dp;
      for (int k = 0; k < DIGITS; k++) begin
        an_d[k] = (idx_q == IDX_W'(k));
      end
    end
    frame_d = wrap;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q       <= '0;
      idx_q       <= '0;
      pend_code_q <= '0;
      pend_dp_q   <= '0;
      disp_code_q <= '0;
      disp_dp_q   <= '0;
      seg_q       <= SEG_BLANK;
      dp_q        <= 1'b0;
      an_q        <= '0;
      frame_q     <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      pend_code_q <= pend_code_d;
      pend_dp_q   <= pend_dp_d;
      disp_code_q <= disp_code_d;
      disp_dp_q   <= disp_dp_d;
      seg_q       <= seg_d;
      dp_q        <= dp_d;
      an_q        <= an_d;
      frame_q     <= frame_d;
    end
  end

  assign seg   = seg_q;
  assign dp    = dp_q;
  assign an    = an_q;
  assign frame = frame_q;

endmodule
